// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART TX serializer: state encoding, line levels
// and parity-type encoding.
package uart_tx_serializer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator for one UART payload word.
module uart_tx_parity_calc
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    always_comb begin
        par_bit = ^data;
        case (par_typ)
            EVEN: par_bit = ^data;
            ODD:  par_bit = ~^data;
        endcase
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start/data/optional parity/stop framing, one bit per CLK.
// Define UART_TX_BACK2BACK_EN to let a byte offered during STOP start the next frame with no idle gap.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state;
    tx_state_e             state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  par_en_q;
    logic                  par_en_next;
    logic                  par_typ_q;
    logic                  par_typ_next;
    logic                  par_bit;
    logic                  accept;
    logic                  tx_next;
    logic                  busy_next;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    // Outputs are decoded from the next state so the line level and Busy
    // change on the same edge as the state they belong to.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        data_next    = data_q;
        cnt_next     = bit_cnt;
        par_en_next  = par_en_q;
        par_typ_next = par_typ_q;
        accept       = 1'b0;
        tx_next      = IDLE_LEVEL;
        busy_next    = 1'b0;

        case (state)
            IDLE: begin
                accept = DATA_VALID;
            end
            START: begin
                state_next = DATA;
                cnt_next   = '0;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    state_next = par_en_q ? PARITY : STOP;
                    cnt_next   = '0;
                end else begin
                    shift_next = shift_reg >> 1;
                    cnt_next   = bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
`ifdef UART_TX_BACK2BACK_EN
                accept     = DATA_VALID;
                state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (accept) begin
            state_next   = START;
            shift_next   = P_DATA;
            data_next    = P_DATA;
            par_en_next  = PAR_EN;
            par_typ_next = PAR_TYP;
            cnt_next     = '0;
        end

        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit;
            STOP:    tx_next = STOP_BIT;
            default: tx_next = IDLE_LEVEL;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            data_q    <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
            TX_OUT    <= IDLE_LEVEL;
            Busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            data_q    <= data_next;
            bit_cnt   <= cnt_next;
            par_en_q  <= par_en_next;
            par_typ_q <= par_typ_next;
            TX_OUT    <= tx_next;
            Busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer: framing table plus handshake,
// back-to-back and mid-frame reset sequences.
module tb_uart_tx_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        int          len;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[7];

    uart_tx_serializer #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic check_idle(input string name);
        checkOutput({name, "_tx"}, TX_OUT, 1'b1);
        checkOutput({name, "_busy"}, Busy, 1'b0);
    endtask

    // One-cycle DATA_VALID pulse; returns with the start bit on the line.
    task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt);
        P_DATA     = data;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
    endtask

    // Checks frame bits 0..len-1, stepping between bits but not after the last.
    task automatic check_bits(input string name, input logic [10:0] frame, input int len,
                              input bit scramble);
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            checkOutput($sformatf("%s_bit%0d", name, i), TX_OUT, frame[i]);
            checkOutput($sformatf("%s_busy%0d", name, i), Busy, 1'b1);
            if (scramble) begin
                P_DATA  = 8'($urandom);
                PAR_EN  = 1'($urandom_range(0, 1));
                PAR_TYP = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, {1'b0, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 11, {1'b1, 1'b1, 8'h07, 1'b0}};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 11, {1'b1, 1'b0, 8'h07, 1'b0}};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 11, {1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 11, {1'b1, 1'b1, 8'hFF, 1'b0}};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 10, {1'b0, 1'b1, 8'h80, 1'b0}};
        vecs[6] = '{8'h3C, 1'b1, 1'b0, 11, {1'b1, 1'b0, 8'h3C, 1'b0}};

        RST        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle($sformatf("reset%0d", i));
        end
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle($sformatf("idle%0d", i));
        end

        $display("[TB] framing table");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].data, vecs[v].par_en, vecs[v].par_typ);
            check_bits($sformatf("vec%0d", v), vecs[v].frame, vecs[v].len, 1'b1);
            tick();
            check_idle($sformatf("vec%0d_end", v));
        end

        $display("[TB] sequencer handshake");
        P_DATA     = 8'h34;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Busy === 1'b1) break;
        end
        checkOutput("hs_busy_rise", Busy, 1'b1);
        DATA_VALID = 1'b0;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        check_bits("hs", {1'b0, 1'b1, 8'h34, 1'b0}, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("hs_once%0d", i));
        end

        $display("[TB] two-byte flow with DATA_VALID during STOP");
        applyStimulus(8'h12, 1'b0, 1'b0);
        check_bits("alu0", {1'b0, 1'b1, 8'h12, 1'b0}, 10, 1'b0);
        P_DATA     = 8'h9C;
        DATA_VALID = 1'b1;
        tick();
`ifndef UART_TX_BACK2BACK_EN
        check_idle("alu_gap");
        tick();
`endif
        DATA_VALID = 1'b0;
        check_bits("alu1", {1'b0, 1'b1, 8'h9C, 1'b0}, 10, 1'b0);
        tick();
        check_idle("alu_end");

        $display("[TB] reset mid-frame");
        applyStimulus(8'hF0, 1'b0, 1'b0);
        check_bits("rst_pre", {1'b0, 1'b1, 8'hF0, 1'b0}, 4, 1'b0);
        tick();
        checkOutput("rst_d3_tx", TX_OUT, 1'b0);
        checkOutput("rst_d3_busy", Busy, 1'b1);
        RST = 1'b1;
        tick();
        check_idle("rst_abort");
        RST = 1'b0;
        tick();
        check_idle("rst_after");
        applyStimulus(8'h55, 1'b0, 1'b0);
        check_bits("post_rst", {1'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b0);
        tick();
        check_idle("post_rst_end");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
